// File: rtl/prog_mem_loader_pkg.sv
// Shared definitions for the program memory / boot loader slice: bus widths
// common with the control unit, loader state encoding and stream byte order.
package prog_mem_loader_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADR_W_DEF  = 6;
  localparam int BYTE_W     = 8;

  // Stream words arrive high byte first.
  localparam bit HI_BYTE_FIRST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RX_HI = 2'd1,
    ST_RX_LO = 2'd2,
    ST_WR    = 2'd3
  } ld_state_e;

  function automatic logic [2*BYTE_W-1:0] pack_word(
    input logic [BYTE_W-1:0] first_b,
    input logic [BYTE_W-1:0] second_b
  );
    pack_word = HI_BYTE_FIRST ? {first_b, second_b} : {second_b, first_b};
  endfunction

endpackage

// File: rtl/prog_mem_loader_spram.sv
// Synchronous single-write-port RAM with a registered, resettable read port.
// Contents are never reset so a loaded program survives a reset.
module spram_sync #(
  parameter int DATA_W = 16,
  parameter int ADR_W  = 6,
  parameter int DEPTH  = 2**ADR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register only updates on a read strobe, so it holds otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem_loader.sv
// Program/data RAM responder for the control unit bus plus a byte-stream boot
// loader that owns the RAM (and holds boot high) while a program is loaded.
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int ADR_W         = ADR_W_DEF,
  parameter int DEPTH         = 2**ADR_W,
  parameter int LOAD_WORDS    = 2**ADR_W,
  parameter bit BOOT_ON_RESET = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ce_i,
  input  logic [ADR_W-1:0]  adr_i,
  input  logic              enable_mem_i,
  input  logic              w_mem_i,
  input  logic [DATA_W-1:0] data_w_i,
  output logic [DATA_W-1:0] data_r_o,
  input  logic              start_load_i,
  input  logic [BYTE_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              boot_o,
  output logic              load_done_o
);

  localparam logic [ADR_W-1:0] LAST_PTR    = ADR_W'(LOAD_WORDS - 1);
  localparam ld_state_e        RESET_STATE = BOOT_ON_RESET ? ST_RX_HI : ST_IDLE;

  ld_state_e         state_q;
  logic [ADR_W-1:0]  load_ptr_q;
  logic [BYTE_W-1:0] hi_byte_q;
  logic              boot_q;
  logic              load_done_q;

  logic              rx_state;
  logic              cpu_ok;
  logic              cpu_wr;
  logic              cpu_rd;
  logic              loader_wr;
  logic [DATA_W-1:0] word_d;
  logic              ram_we_d;
  logic [ADR_W-1:0]  ram_waddr_d;
  logic [DATA_W-1:0] ram_wdata_d;

  assign rx_state   = (state_q == ST_RX_HI) || (state_q == ST_RX_LO);
  assign rx_ready_o = ce_i & rx_state;

  // The CPU bus is only live while the loader is parked and the clock is enabled.
  assign cpu_ok    = ce_i & ~boot_q;
  assign cpu_wr    = cpu_ok & enable_mem_i & w_mem_i;
  assign cpu_rd    = cpu_ok & enable_mem_i & ~w_mem_i;
  assign loader_wr = rx_ready_o & rx_valid_i & (state_q == ST_RX_LO);
  assign word_d    = DATA_W'(pack_word(hi_byte_q, rx_data_i));

  // loader_wr implies boot_q=1, so the two writers never collide.
  always_comb begin
    ram_we_d    = loader_wr | cpu_wr;
    ram_waddr_d = adr_i;
    ram_wdata_d = data_w_i;
    if (loader_wr) begin
      ram_waddr_d = load_ptr_q;
      ram_wdata_d = word_d;
    end
  end

  spram_sync #(
    .DATA_W (DATA_W),
    .ADR_W  (ADR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (ram_we_d),
    .waddr_i (ram_waddr_d),
    .wdata_i (ram_wdata_d),
    .re_i    (cpu_rd),
    .raddr_i (adr_i),
    .rdata_o (data_r_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RESET_STATE;
      load_ptr_q  <= '0;
      hi_byte_q   <= '0;
      boot_q      <= BOOT_ON_RESET;
      load_done_q <= 1'b0;
    end else if (ce_i) begin
      load_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_load_i) begin
            state_q    <= ST_RX_HI;
            load_ptr_q <= '0;
            boot_q     <= 1'b1;
          end
        end
        ST_RX_HI: begin
          if (rx_valid_i) begin
            hi_byte_q <= rx_data_i;
            state_q   <= ST_RX_LO;
          end
        end
        ST_RX_LO: begin
          if (rx_valid_i) begin
            state_q <= ST_WR;
          end
        end
        ST_WR: begin
          // boot drops on the same edge that load_done rises.
          if (load_ptr_q == LAST_PTR) begin
            state_q     <= ST_IDLE;
            boot_q      <= 1'b0;
            load_done_q <= 1'b1;
          end else begin
            load_ptr_q <= load_ptr_q + 1'b1;
            state_q    <= ST_RX_HI;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign boot_o      = boot_q;
  assign load_done_o = load_done_q;

endmodule
